// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: queues ALU command bundles in a small FIFO and issues
// them one per cycle onto registered ALU drive outputs.
//
// Handshake: a command is pushed on a rising edge where cmd_valid && cmd_ready.
// cmd_ready is combinational and depends only on FIFO occupancy, flush and rst,
// never on cmd_valid. There is no same-cycle pass-through when the FIFO is full.
//
// The FSM (IDLE/ISSUE/PAUSE) decides when the FIFO head may be popped. Its
// next-state decisions look at the occupancy *after* this edge's push/pop, so a
// command pushed into an empty FIFO at edge N is issued at edge N+1.
// Every edge without a pop drives the all-zero bubble onto the outputs.
//
// Optional feature: define ALU_ISSUE_STATS_EN to add the saturating 16-bit
// issued_cnt output. It counts pops, clears on rst and is not cleared by flush.
module alu_cmd_issuer #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [WIDTH-1:0]           cmd_A,
    input  logic [WIDTH-1:0]           cmd_B,
    input  logic                       cmd_ALU_en,
    input  logic                       cmd_a_en,
    input  logic                       cmd_b_en,
    input  logic [2:0]                 cmd_a_op,
    input  logic [1:0]                 cmd_b_op,
    input  logic                       hold,
    input  logic                       flush,
    output logic [WIDTH-1:0]           A,
    output logic [WIDTH-1:0]           B,
    output logic                       ALU_en,
    output logic                       a_en,
    output logic                       b_en,
    output logic [2:0]                 a_op,
    output logic [1:0]                 b_op,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       issue_busy,
    output logic [1:0]                 dbg_state_o
`ifdef ALU_ISSUE_STATS_EN
    ,
    output logic [15:0]                issued_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             alu_en;
        logic             a_en;
        logic             b_en;
        logic [2:0]       a_op;
        logic [1:0]       b_op;
    } cmd_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    cmd_t            out_q, out_d;
    cmd_t            mem_q [DEPTH];
    cmd_t            cmd_in;
    logic            push;
    logic            pop;
    logic            nonempty_d;

    assign cmd_in    = {cmd_A, cmd_B, cmd_ALU_en, cmd_a_en, cmd_b_en, cmd_a_op, cmd_b_op};
    assign cmd_ready = !rst && !flush && (count_q < FULL_C);

    // Next-state logic: push/pop decode, pointers, occupancy, FSM and output bundle.
    always_comb begin
        push       = cmd_valid && cmd_ready;
        pop        = (state_q == ST_ISSUE) && (count_q != '0) && !hold && !flush;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        state_d    = state_q;
        out_d      = '0;
        nonempty_d = 1'b0;

        // Pointers are AW bits wide, so incrementing wraps modulo DEPTH.
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            out_d    = mem_q[rd_ptr_q];
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        nonempty_d = (count_d != '0);

        case (state_q)
            ST_IDLE: begin
                if (nonempty_d) begin
                    state_d = hold ? ST_PAUSE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (hold) begin
                    state_d = ST_PAUSE;
                end else if (!nonempty_d) begin
                    state_d = ST_IDLE;
                end
            end
            ST_PAUSE: begin
                if (!nonempty_d) begin
                    state_d = ST_IDLE;
                end else if (!hold) begin
                    state_d = ST_ISSUE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Flush wins over push, pop and hold: empty everything and go idle.
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            state_d  = ST_IDLE;
            out_d    = '0;
        end
    end

    // Control and output registers; rst dominates everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            out_q    <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            out_q    <= out_d;
        end
    end

    // FIFO storage; data needs no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= cmd_in;
        end
    end

    assign A           = out_q.a;
    assign B           = out_q.b;
    assign ALU_en      = out_q.alu_en;
    assign a_en        = out_q.a_en;
    assign b_en        = out_q.b_en;
    assign a_op        = out_q.a_op;
    assign b_op        = out_q.b_op;
    assign fifo_count  = count_q;
    assign issue_busy  = (state_q == ST_ISSUE);
    assign dbg_state_o = state_q;

`ifdef ALU_ISSUE_STATS_EN
    logic [15:0] issued_q;

    // Saturating pop counter; flush never pops, so it leaves the count alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            issued_q <= '0;
        end else if (pop && (issued_q != 16'hFFFF)) begin
            issued_q <= issued_q + 16'd1;
        end
    end

    assign issued_cnt = issued_q;
`endif

endmodule

// File: doc/alu_cmd_issuer.md
ALU_CMD_ISSUER -- requirements
Module: alu_cmd_issuer

Interface
REQ-001 SHALL have parameter WIDTH, default 5, ALU operand width.
REQ-002 SHALL have parameter DEPTH, default 4, command FIFO depth (power of two, >=2).
REQ-003 SHALL provide ports clk (input, 1: sole clock) and rst (input, 1: reset); one clock; reset is synchronous and active-high.
REQ-004 SHALL provide input cmd_valid, 1: upstream command present.
REQ-005 SHALL provide output cmd_ready, 1: issuer accepts a command this cycle.
REQ-006 SHALL provide inputs cmd_A and cmd_B, WIDTH each: operands.
REQ-007 SHALL provide inputs cmd_ALU_en, cmd_a_en and cmd_b_en, 1 each: ALU control bits.
REQ-008 SHALL provide inputs cmd_a_op (3) and cmd_b_op (2): opcodes.
REQ-009 SHALL provide input hold, 1: pause issue.
REQ-010 SHALL provide input flush, 1: discard all queued commands.
REQ-011 SHALL provide outputs A and B (WIDTH each), ALU_en, a_en and b_en (1 each), a_op (3) and b_op (2): registered ALU drive.
REQ-012 SHALL provide output fifo_count, $clog2(DEPTH)+1 bits: entries held.
REQ-013 SHALL provide output issue_busy, 1: state is ISSUE.

Function
REQ-014 Push SHALL occur on a rising edge where cmd_valid && cmd_ready; the entry is the full cmd_* bundle.
REQ-015 cmd_ready SHALL be combinational: (fifo_count < DEPTH) && !flush; no same-cycle pass-through when full.
REQ-016 Pop SHALL occur on an edge where the state is ISSUE and fifo_count > 0 and !hold and !flush; the popped bundle is registered onto the ALU outputs at that edge.
REQ-017 Latency: a command pushed into an empty FIFO at edge N SHALL appear on the outputs after edge N+1; throughput is one command per cycle.
REQ-018 On any edge without a pop, the outputs SHALL take the bubble: ALU_en=0, A=B=0, a_en=b_en=0, a_op=0, b_op=0.
REQ-019 FSM states SHALL be IDLE, ISSUE and PAUSE.
REQ-020 IDLE->ISSUE SHALL occur when the FIFO is non-empty and hold=0.
REQ-021 IDLE->PAUSE SHALL occur when the FIFO is non-empty and hold=1.
REQ-022 ISSUE->PAUSE SHALL occur on hold=1; ISSUE->IDLE SHALL occur when a pop empties the FIFO and no push occurs.
REQ-023 PAUSE->ISSUE SHALL occur on hold=0 with the FIFO non-empty; PAUSE->IDLE SHALL occur when the FIFO is empty.
REQ-024 Simultaneous push and pop SHALL leave fifo_count unchanged.
REQ-025 Read and write pointers SHALL wrap modulo DEPTH.
REQ-026 flush SHALL take priority over push, pop and hold: at that edge count=0, pointers=0, state=IDLE, outputs=bubble.
REQ-027 Commands SHALL issue in strict FIFO order.

Reset
REQ-028 When rst=1 at an edge: FIFO empty, pointers 0, state IDLE, all ALU outputs at bubble values, fifo_count=0, issue_busy=0.
REQ-029 rst SHALL dominate flush, push and pop; cmd_ready SHALL be 0 while rst=1.
REQ-030 Reset mid-burst SHALL drop all queued commands; the first edge after release issues nothing.

Configuration
REQ-031 Macro ALU_ISSUE_STATS_EN, when defined, SHALL add output issued_cnt (16 bit), which increments per pop, saturates at 16'hFFFF, and clears on rst but not on flush.
REQ-032 Without ALU_ISSUE_STATS_EN, the port and counter SHALL be absent; all other behaviour is identical.

Verification
REQ-033 After reset, push A=5'h03, B=5'h01, a_en=1, a_op=0, ALU_en=1 -> outputs show that bundle exactly one edge later; ALU_en=0 on the following cycle.
REQ-034 With hold=1, push 5 commands -> cmd_ready=0 after the 4th push, fifo_count=4, state PAUSE; release hold -> 4 commands issue in order on 4 consecutive cycles.
REQ-035 With continuous cmd_valid, hold=0 and 10 commands -> 10 consecutive issues, fifo_count never exceeds 1, and pointers wrap twice cleanly.
REQ-036 Assert flush with 3 queued and cmd_valid=1 -> push dropped, fifo_count=0, next output is a bubble, state IDLE.
REQ-037 Assert rst while issuing the 2nd of 4 commands -> all outputs are bubbles and nothing issues afterward; issued_cnt=0 (stats build).
REQ-038 Stats build: force 65540 pops -> issued_cnt holds 16'hFFFF.
